// File: rtl/ram_ctrl_pkg.sv
// Shared encodings and defaults for the single-port RAM access sequencer.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic P_FETCH = 1'b0;
  localparam logic P_LSU   = 1'b1;

  // 2'b11 is unused and steered back to IDLE by the sequencer
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request arbiter with LAST pointer; `ARB_FIXED_PRIO_EN selects fixed
// port-0 priority and removes the pointer.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] win_c
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst_n, upd};

  always_comb begin
    win_c = 2'b00;
    if (req[P_FETCH]) begin
      win_c[P_FETCH] = 1'b1;
    end else if (req[P_LSU]) begin
      win_c[P_LSU] = 1'b1;
    end
  end
`else
  logic last_q;

  // LAST points at the port granted most recently; reset favours port 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (upd && (win_c != 2'b00)) begin
      last_q <= win_c[P_LSU];
    end
  end

  always_comb begin
    win_c = 2'b00;
    case (req)
      2'b01:   win_c = 2'b01;
      2'b10:   win_c = 2'b10;
      2'b11:   win_c = last_q ? 2'b01 : 2'b10;
      default: win_c = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/ram_access_arbiter.sv
// Fetch/LSU arbiter and IDLE->ACCESS->DONE sequencer for the single-port RAM.
// Define ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module ram_access_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              cs,
  output logic              w,
  output logic              r,
  output logic [ADDR_W-1:0] maddr,
  output logic [DATA_W-1:0] mdata_out,
  input  logic [DATA_W-1:0] mdata_in
);

  state_e            state_q, state_d;
  logic [1:0]        win_c;
  logic              ld_c;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              cs_d, w_d, r_d;
  logic              gnt0_d, gnt1_d, done0_d, done1_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1, req0}),
    .upd   (ld_c),
    .win_c (win_c)
  );

  // Next state, request latch and strobe decode; strobes are registered
  // from this so they depend only on state and latched winner/WE.
  always_comb begin
    state_d = state_q;
    ld_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCESS;
          ld_c    = 1'b1;
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = maddr;
    wdata_d = mdata_out;
    if (ld_c) begin
      sel_d   = win_c[P_LSU] & ~win_c[P_FETCH];
      we_d    = sel_d ? we1 : we0;
      addr_d  = sel_d ? addr1 : addr0;
      wdata_d = sel_d ? wdata1 : wdata0;
    end

    cs_d    = (state_d == ACCESS);
    w_d     = cs_d & we_d;
    r_d     = cs_d & ~we_d;
    gnt0_d  = cs_d & ~sel_d;
    gnt1_d  = cs_d & sel_d;
    done0_d = (state_d == DONE) & ~sel_d;
    done1_d = (state_d == DONE) & sel_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      cs        <= 1'b0;
      w         <= 1'b0;
      r         <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      maddr     <= '0;
      mdata_out <= '0;
      rdata     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cs        <= cs_d;
      w         <= w_d;
      r         <= r_d;
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      done0     <= done0_d;
      done1     <= done1_d;
      maddr     <= addr_d;
      mdata_out <= wdata_d;
      // Array data is only trusted on the edge closing a read ACCESS
      if ((state_q == ACCESS) && r) begin
        rdata <= mdata_in;
      end
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter with a behavioural RAM array.
module tb_ram_access_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] rdata;
  logic          cs, w, r;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata_out;
  logic [DW-1:0] mdata_in;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs [10];
  logic [DW-1:0] mem [16] = '{default: 8'h00};

  ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .rdata     (rdata),
    .cs        (cs),
    .w         (w),
    .r         (r),
    .maddr     (maddr),
    .mdata_out (mdata_out),
    .mdata_in  (mdata_in)
  );

  always #5 clk = ~clk;

  // Array model: writes on the edge with CS&W, junk on the bus unless reading
  always @(posedge clk) if (cs && w) mem[maddr] <= mdata_out;
  assign mdata_in = (cs && r) ? mem[maddr] : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe sanity every cycle, and scoreboard on every DONE pulse
  always @(negedge clk) begin
    check("strobe_excl", 32'((w & r) | ((w | r) & ~cs)), 32'd0);
    if (done0 || done1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'({done1, done0}), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_port", 32'({done1, done0}), mon_e.port ? 32'd2 : 32'd1);
        check("rdata", 32'(rdata), 32'(mon_e.rdata));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic port, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.port, v.we, v.addr, v.wdata);
    sb_q.push_back(exp_t'{port: v.port, rdata: v.exp_rdata});
    @(negedge clk);
    check("gnt", 32'({gnt1, gnt0}), v.port ? 32'd2 : 32'd1);
    check("cs_w_r", 32'({cs, w, r}), 32'({1'b1, v.we, ~v.we}));
    check("maddr", 32'(maddr), 32'(v.addr));
    if (v.we) check("mdata_out", 32'(mdata_out), 32'(v.wdata));
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    check("done_cycle", 32'({cs, w, r, gnt1, gnt0}), 32'd0);
  endtask

  initial begin
    logic exp_order [4];
    int   ng;

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    vecs[0] = '{1'b0, 1'b1, 4'h3, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 4'h3, 8'h00, 8'hA5};
    vecs[2] = '{1'b0, 1'b1, 4'h5, 8'h5A, 8'hA5};
    vecs[3] = '{1'b0, 1'b0, 4'h5, 8'h00, 8'h5A};
    vecs[4] = '{1'b1, 1'b1, 4'h6, 8'hC3, 8'h5A};
    vecs[5] = '{1'b1, 1'b0, 4'h6, 8'h00, 8'hC3};
    vecs[6] = '{1'b0, 1'b1, 4'hF, 8'h11, 8'hC3};
    vecs[7] = '{1'b1, 1'b0, 4'hF, 8'h00, 8'h11};
    vecs[8] = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h00};
    vecs[9] = '{1'b1, 1'b0, 4'h5, 8'h00, 8'h5A};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_ctrl", 32'({cs, w, r, gnt1, gnt0, done1, done0}), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_maddr", 32'(maddr), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Both ports requesting continuously from reset
    do_reset();
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 4; i++)
      sb_q.push_back(exp_t'{port: exp_order[i], rdata: exp_order[i] ? 8'hC3 : 8'hA5});
    drive(1'b0, 1'b0, 4'h3, 8'h00);
    drive(1'b1, 1'b0, 4'h6, 8'h00);
    ng = 0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        check("grant_order", 32'({gnt1, gnt0}), exp_order[ng] ? 32'd2 : 32'd1);
        ng++;
      end
    end
    check("grant_count", 32'(ng), 32'd4);
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during a read ACCESS aborts it and clears RDATA
    drive(1'b0, 1'b0, 4'h5, 8'h00);
    @(negedge clk);
    check("abort_rd_gnt", 32'({gnt1, gnt0, r}), 32'b011);
    rst_n = 1'b0;
    req0 = 1'b0;
    @(negedge clk);
    check("abort_rd_ctrl", 32'({cs, done1, done0}), 32'd0);
    check("abort_rd_rdata", 32'(rdata), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_rd_nodone", 32'({done1, done0}), 32'd0);

    // Reset during a write ACCESS still commits the write
    drive(1'b1, 1'b1, 4'h2, 8'h3C);
    @(negedge clk);
    check("abort_wr_gnt", 32'({gnt1, gnt0, w}), 32'b101);
    rst_n = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    check("abort_wr_ctrl", 32'({cs, done1, done0}), 32'd0);
    rst_n = 1'b1;
    run_vec('{1'b0, 1'b0, 4'h2, 8'h00, 8'h3C});

    // Quiet bus
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_quiet", 32'({cs, w, r, gnt1, gnt0, done1, done0}), 32'd0);
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

Two-requester arbiter and sequencer for the single-port binary-cell RAM array in the processor. It shares the array between the instruction-fetch port (port 0) and the load/store port (port 1). It converts each accepted request into one chip-select cycle with the correct W/R strobe, then returns read data with a one-cycle done pulse. It sits between the core's fetch/LSU logic and the array's CS/W/R/address/data pins.

## Interface
- ADDR_W, 4, RAM word-address width
- DATA_W, 8, RAM word width
- CLK  in  1  rising-edge clock shared with the RAM array
- RST_N  in  1  reset, synchronous, active-low
- REQ0 / REQ1  in  1  request from port 0 / port 1
- WE0 / WE1  in  1  1 = write, 0 = read; qualified by REQx
- ADDR0 / ADDR1  in  ADDR_W  word address
- WDATA0 / WDATA1  in  DATA_W  write data
- GNT0 / GNT1  out  1  request accepted (one-cycle pulse)
- DONE0 / DONE1  out  1  access complete (one-cycle pulse); RDATA valid when the access was a read
- RDATA  out  DATA_W  read data register, shared by both ports
- CS  out  1  array chip select
- W / R  out  1  array write / read strobes
- MADDR  out  ADDR_W  array address
- MDATA_OUT  out  DATA_W  array write data
- MDATA_IN  in  DATA_W  array read data; X when CS&R is low

## Operation
- FSM states:
  - IDLE: CS=W=R=0. If REQ0|REQ1, pick a winner, latch its WE, ADDR and WDATA, and go to ACCESS. Otherwise stay.
  - ACCESS: CS=1. W=latched WE, R=~latched WE. MADDR and MDATA_OUT come from the latched registers. GNTx=1 for the winner. On a read, RDATA loads MDATA_IN at the closing edge. Always go to DONE.
  - DONE: CS=W=R=0. DONEx=1 for the winner. Go to IDLE.
- Arbitration when only one port requests: that port wins.
- Arbitration on a tie: round-robin. The winner is the port not granted last. The LAST pointer updates only on a grant.
- Requester rule: hold REQ, WE, ADDR and WDATA stable from assertion until GNT is seen. Drop REQ no later than the DONE cycle. Any REQ high in IDLE is a new request.
- RDATA holds its value except on the closing edge of a read ACCESS. X from the array never enters RDATA.
- Reset (RST_N low at any edge):
  - next state IDLE; all outputs 0; RDATA=0; LAST=1, so port 0 wins the first tie.
  - No DONE is issued for an aborted access.
  - A write whose ACCESS cycle was live at the reset edge still commits in the array, because CS and W were high at that edge.

## Timing
- A request sampled in IDLE at edge N gives ACCESS in cycle N+1 (GNT high) and DONE in cycle N+2. The next IDLE sample is edge N+3.
- Throughput: one access per 3 cycles. A continuously requesting pair alternates 0,1,0,1.
- Read latency: RDATA valid in the DONE cycle, 2 cycles after the sampling edge. It stays valid until the next read.
- Write commits at the rising edge that ends ACCESS.
- CS, W, R, GNTx and DONEx are decoded from the state register and latched winner/WE only, so they are glitch-free. They never depend combinationally on REQ.
- W and R are never high together. W and R are never high without CS.

## Configuration
- ARB_FIXED_PRIO_EN defined: port 0 always wins a tie and the LAST pointer is not implemented. A port-0 request present at every IDLE sample starves port 1.
- ARB_FIXED_PRIO_EN undefined (default): round-robin as above.

## Structure
- Shared package ram_ctrl_pkg holds:
  - state encoding: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10; 2'b11 is illegal and recovers to IDLE
  - port index constants P_FETCH=0, P_LSU=1
  - default ADDR_W and DATA_W
- Sub-module rr_arb2 holds the two-request arbiter and the LAST pointer. Inputs: req[1:0], update enable. Output: a one-hot winner. The ARB_FIXED_PRIO_EN variant lives inside it.
- The top level holds the FSM, the request latches, the RDATA register and the output decode.

## Test plan
- Reset, then REQ0=1, WE0=1, ADDR0=4'h3, WDATA0=8'hA5 → GNT0 in cycle 2, array sees CS=1 W=1 MADDR=3, DONE0 in cycle 3.
- Then REQ1=1, WE1=0, ADDR1=4'h3 → GNT1 with CS=1 R=1, DONE1 with RDATA=8'hA5.
- REQ0 and REQ1 both held high for 4 accesses after reset → grant order 0,1,0,1. With ARB_FIXED_PRIO_EN the order is 0,0,0,0.
- A read of address 5 followed by a write to address 6 → RDATA keeps the address-5 value through the write DONE and never goes X.
- RST_N low during an ACCESS read → no DONE, RDATA=0, CS=0 next cycle. With RST_N low during an ACCESS write of 8'h3C to address 2, a later read of address 2 returns 8'h3C.
- Idle with REQ0=REQ1=0 for 10 cycles → CS, W, R, GNT and DONE stay 0. Over all tests, the assertion "W&R never, (W|R) implies CS" holds every cycle.
